// File: rtl/call_return_unit_pkg.sv
// call_return_unit_pkg: shared cpu-stack state encoding and call/return defaults
package call_return_unit_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PUSH = 3'd1;
    localparam logic [2:0] S_POP  = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic        OP_PUSH_DEF    = 1'b1;
    localparam logic [15:0] RET_OFFSET_DEF = 16'd1;

endpackage

// File: rtl/call_return_unit.sv
// call_return_unit: sequences call/return through an external hardware stack
module call_return_unit
    import call_return_unit_pkg::*;
#(
    parameter logic        OP_PUSH    = OP_PUSH_DEF,
    parameter logic [15:0] RET_OFFSET = RET_OFFSET_DEF,
    parameter int          DEPTH_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               call_req,
    input  logic               ret_req,
    input  logic [15:0]        pc_in,
    input  logic [15:0]        target_addr,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               pc_load,
    output logic [15:0]        pc_out,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf,
    output logic               unf,
    output logic               stk_enable,
    output logic               stk_operation,
    output logic [15:0]        stk_wdata,
    input  logic [15:0]        stk_rdata,
    input  logic               stk_full,
    input  logic               stk_empty
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    logic [2:0]         state_q, state_d;
    logic [15:0]        ret_q, ret_d, tgt_q, tgt_d, pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d, ovf_q, ovf_d, unf_q, unf_d;

    // Next-state: rejected requests skip the stack and go straight to FIN with err set
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        tgt_d   = tgt_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            S_IDLE: begin
                if (call_req) begin
                    err_d   = stk_full;
                    ovf_d   = ovf_q | stk_full;
                    ret_d   = stk_full ? ret_q : pc_in + RET_OFFSET;
                    tgt_d   = stk_full ? tgt_q : target_addr;
                    state_d = stk_full ? S_FIN : S_PUSH;
                end else if (ret_req) begin
                    err_d   = stk_empty;
                    unf_d   = unf_q | stk_empty;
                    state_d = stk_empty ? S_FIN : S_POP;
                end
            end
            S_PUSH: begin
                depth_d = (depth_q == DEPTH_MAX) ? depth_q : depth_q + 1'b1;
                pc_d    = tgt_q;
                state_d = S_FIN;
            end
            S_POP: begin
                depth_d = (depth_q == '0) ? depth_q : depth_q - 1'b1;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                pc_d    = stk_rdata;
                state_d = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ret_q   <= '0;
            tgt_q   <= '0;
            pc_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            tgt_q   <= tgt_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign busy          = state_q != S_IDLE;
    assign done          = state_q == S_FIN;
    assign err           = done & err_q;
    assign pc_load       = done & ~err_q;
    assign pc_out        = pc_q;
    assign depth         = depth_q;
    assign ovf           = ovf_q;
    assign unf           = unf_q;
    assign stk_enable    = (state_q == S_PUSH) | (state_q == S_POP);
    assign stk_operation = (state_q == S_PUSH) ? OP_PUSH : ~OP_PUSH;
    assign stk_wdata     = ret_q;

endmodule
